// File: rtl/sense_scheduler_if.sv
// Sensor-pin and result bundle between the measurement sequencer and its environment.
interface sense_scheduler_if;
  logic        en;
  logic        trig;
  logic        echo;
  logic        adc_soc;
  logic        adc_eoc;
  logic [11:0] adc_dout;
  logic [15:0] dist_cm;
  logic        dist_vld;
  logic [11:0] temp_raw;
  logic        temp_vld;
  logic        echo_err;
  logic        adc_err;
  logic        near_alarm;
  logic        busy;

  modport master (
    input  en, echo, adc_eoc, adc_dout,
    output trig, adc_soc, dist_cm, dist_vld, temp_raw, temp_vld,
           echo_err, adc_err, near_alarm, busy
  );

  modport slave (
    output en, echo, adc_eoc, adc_dout,
    input  trig, adc_soc, dist_cm, dist_vld, temp_raw, temp_vld,
           echo_err, adc_err, near_alarm, busy
  );
endinterface

// File: rtl/sense_scheduler.sv
// Periodic sequencer: one ultrasonic range measurement, then one ADC conversion.
// Optional macro SENSE_ALARM_HYST_EN adds hysteresis to near_alarm.
module sense_scheduler #(
  parameter int unsigned PERIOD_CYC  = 32'd4_800_000,
  parameter int unsigned TRIG_CYC    = 32'd240,
  parameter int unsigned CM_CYC      = 32'd1392,
  parameter int unsigned ECHO_TO_CYC = 32'd720_000,
  parameter int unsigned SOC_CYC     = 32'd4,
  parameter int unsigned ADC_TO_CYC  = 32'd48_000,
  parameter int unsigned NEAR_CM     = 32'd60,
  parameter int unsigned HYST_CM     = 32'd5
) (
  input  logic              clk,
  input  logic              rst_n,
  sense_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    ECHO_RISE = 3'd2,
    ECHO_MEAS = 3'd3,
    SOC       = 3'd4,
    EOC_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  if ((PERIOD_CYC < 32'd64) || ((NEAR_CM + HYST_CM) > 32'd65535)) begin : g_cfg_err
    $error("sense_scheduler: PERIOD_CYC below 64 or alarm threshold exceeds 16 bits");
  end

  state_t      state_r;
  logic [31:0] period_cnt_r;
  logic [31:0] tmr_r;
  logic [31:0] sub_cnt_r;
  logic [15:0] cm_cnt_r;
  logic [2:0]  echo_sync_r;
  logic [2:0]  eoc_sync_r;
  logic        tick_s;
  logic        echo_rise_s;
  logic        echo_fall_s;
  logic        eoc_rise_s;

  // Stage [2] is the previous synchronised value, used only for edge detection.
  assign tick_s      = (period_cnt_r == (PERIOD_CYC - 32'd1));
  assign echo_rise_s = echo_sync_r[1] & ~echo_sync_r[2];
  assign echo_fall_s = ~echo_sync_r[1] & echo_sync_r[2];
  assign eoc_rise_s  = eoc_sync_r[1] & ~eoc_sync_r[2];

  // Free-running period counter and input synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_r <= 32'd0;
      echo_sync_r  <= 3'd0;
      eoc_sync_r   <= 3'd0;
    end else begin
      period_cnt_r <= tick_s ? 32'd0 : (period_cnt_r + 32'd1);
      echo_sync_r  <= {echo_sync_r[1:0], bus.echo};
      eoc_sync_r   <= {eoc_sync_r[1:0], bus.adc_eoc};
    end
  end

  // Measurement sequencer with registered pin drives and result strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      tmr_r          <= 32'd0;
      sub_cnt_r      <= 32'd0;
      cm_cnt_r       <= 16'd0;
      bus.trig       <= 1'b0;
      bus.adc_soc    <= 1'b0;
      bus.dist_cm    <= 16'd0;
      bus.dist_vld   <= 1'b0;
      bus.temp_raw   <= 12'd0;
      bus.temp_vld   <= 1'b0;
      bus.echo_err   <= 1'b0;
      bus.adc_err    <= 1'b0;
      bus.near_alarm <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.dist_vld <= 1'b0;
      bus.temp_vld <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s && bus.en) begin
            state_r  <= TRIG;
            tmr_r    <= 32'd0;
            bus.trig <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        TRIG: begin
          if (tmr_r == (TRIG_CYC - 32'd1)) begin
            state_r  <= ECHO_RISE;
            tmr_r    <= 32'd0;
            bus.trig <= 1'b0;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        ECHO_RISE: begin
          if (echo_rise_s) begin
            state_r   <= ECHO_MEAS;
            tmr_r     <= 32'd0;
            sub_cnt_r <= 32'd0;
            cm_cnt_r  <= 16'd0;
          end else if (tmr_r == (ECHO_TO_CYC - 32'd1)) begin
            state_r      <= SOC;
            tmr_r        <= 32'd0;
            bus.echo_err <= 1'b1;
            bus.adc_soc  <= 1'b1;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        ECHO_MEAS: begin
          if (echo_fall_s) begin
            state_r      <= SOC;
            tmr_r        <= 32'd0;
            bus.adc_soc  <= 1'b1;
            bus.dist_cm  <= cm_cnt_r;
            bus.dist_vld <= 1'b1;
            bus.echo_err <= 1'b0;
`ifdef SENSE_ALARM_HYST_EN
            if (cm_cnt_r < 16'(NEAR_CM)) begin
              bus.near_alarm <= 1'b1;
            end else if (cm_cnt_r >= 16'(NEAR_CM + HYST_CM)) begin
              bus.near_alarm <= 1'b0;
            end else begin
              bus.near_alarm <= bus.near_alarm;
            end
`else
            bus.near_alarm <= (cm_cnt_r < 16'(NEAR_CM));
`endif
          end else if (tmr_r == (ECHO_TO_CYC - 32'd1)) begin
            state_r      <= SOC;
            tmr_r        <= 32'd0;
            bus.adc_soc  <= 1'b1;
            bus.echo_err <= 1'b1;
          end else begin
            tmr_r <= tmr_r + 32'd1;
            // A partial centimetre left in sub_cnt_r at the fall is dropped.
            if (echo_sync_r[1]) begin
              if (sub_cnt_r == (CM_CYC - 32'd1)) begin
                sub_cnt_r <= 32'd0;
                if (cm_cnt_r != 16'hFFFF) begin
                  cm_cnt_r <= cm_cnt_r + 16'd1;
                end
              end else begin
                sub_cnt_r <= sub_cnt_r + 32'd1;
              end
            end
          end
        end
        SOC: begin
          if (tmr_r == (SOC_CYC - 32'd1)) begin
            state_r     <= EOC_WAIT;
            tmr_r       <= 32'd0;
            bus.adc_soc <= 1'b0;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        EOC_WAIT: begin
          if (eoc_rise_s) begin
            state_r      <= DONE;
            bus.temp_raw <= bus.adc_dout;
            bus.temp_vld <= 1'b1;
            bus.adc_err  <= 1'b0;
          end else if (tmr_r == (ADC_TO_CYC - 32'd1)) begin
            state_r     <= DONE;
            bus.adc_err <= 1'b1;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          bus.trig    <= 1'b0;
          bus.adc_soc <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sense_scheduler.sv
// Directed scoreboard bench for sense_scheduler: range, ADC, timeouts, alarm, reset.
module tb_sense_scheduler;

  localparam int unsigned PER   = 32'd2000;
  localparam int unsigned TRIGC = 32'd10;
  localparam int unsigned CMC   = 32'd20;
  // 60-70 cm echoes last up to ~1410 cycles at 20 cycles/cm, so the echo
  // timeout must sit above that for the alarm sequence to complete.
  localparam int unsigned ETO   = 32'd1500;
  localparam int unsigned SOCC  = 32'd4;
  localparam int unsigned ATO   = 32'd100;

`ifdef SENSE_ALARM_HYST_EN
  localparam logic ALARM_62 = 1'b1;
`else
  localparam logic ALARM_62 = 1'b0;
`endif

  localparam int W_TRIG = 0;
  localparam int W_SOC  = 1;
  localparam int W_DVLD = 2;
  localparam int W_TVLD = 3;
  localparam int W_EERR = 4;
  localparam int W_AERR = 5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic [15:0] q_dist[$];
  logic        q_alarm[$];
  logic [11:0] q_temp[$];
  logic [11:0] last_temp;

  sense_scheduler_if bus ();

  sense_scheduler #(
    .PERIOD_CYC (PER),
    .TRIG_CYC   (TRIGC),
    .CM_CYC     (CMC),
    .ECHO_TO_CYC(ETO),
    .SOC_CYC    (SOCC),
    .ADC_TO_CYC (ATO),
    .NEAR_CM    (32'd60),
    .HYST_CM    (32'd5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic sig_of(input int w);
    case (w)
      W_TRIG:  return bus.trig;
      W_SOC:   return bus.adc_soc;
      W_DVLD:  return bus.dist_vld;
      W_TVLD:  return bus.temp_vld;
      W_EERR:  return bus.echo_err;
      W_AERR:  return bus.adc_err;
      default: return bus.busy;
    endcase
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({bus.trig, bus.adc_soc, bus.dist_cm, bus.dist_vld, bus.temp_raw,
                bus.temp_vld, bus.echo_err, bus.adc_err, bus.near_alarm, bus.busy});
  endfunction

  task automatic wait_for(input int w, input logic val, input int max_cyc,
                          input string tag, output int n);
    n = 0;
    while (sig_of(w) !== val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sig_of(w)), 64'(val));
  endtask

  // echo_len == 0: echo never rises; eoc_dly == 0: eoc never rises.
  task automatic run_seq(input int echo_len, input logic [15:0] e_dist, input logic e_alarm,
                         input int eoc_dly, input logic [11:0] dout, input bit drop_en);
    int          n;
    bit          soc_early;
    logic [15:0] d;
    logic        a;
    logic [11:0] t;
    wait_for(W_TRIG, 1'b1, int'(PER) + 50, "trig_rise", n);
    if (drop_en) bus.en = 1'b0;
    wait_for(W_TRIG, 1'b0, 50, "trig_fall", n);
    chk("trig_width", 64'(n), 64'(TRIGC));
    if (echo_len > 0) begin
      repeat (5) @(negedge clk);
      soc_early = 1'b0;
      bus.echo  = 1'b1;
      repeat (echo_len) begin
        @(negedge clk);
        if (bus.adc_soc !== 1'b0) soc_early = 1'b1;
      end
      bus.echo = 1'b0;
      q_dist.push_back(e_dist);
      q_alarm.push_back(e_alarm);
      wait_for(W_DVLD, 1'b1, 10, "dist_vld", n);
      chk("dist_latency", 64'(n), 64'd3);
      d = q_dist.pop_front();
      a = q_alarm.pop_front();
      chk("dist_cm", 64'(bus.dist_cm), 64'(d));
      chk("near_alarm", 64'(bus.near_alarm), 64'(a));
      chk("echo_err_clr", 64'(bus.echo_err), 64'd0);
      chk("soc_after_fall", 64'(bus.adc_soc), 64'd1);
      chk("soc_during_echo", 64'(soc_early), 64'd0);
      @(negedge clk);
      chk("dist_vld_pulse", 64'(bus.dist_vld), 64'd0);
      wait_for(W_SOC, 1'b0, 20, "soc_fall", n);
      chk("soc_width", 64'(n + 1), 64'(SOCC));
    end else begin
      wait_for(W_EERR, 1'b1, int'(ETO) + 20, "echo_err_set", n);
      chk("echo_to_cycles", 64'(n), 64'(ETO));
      chk("dist_held", 64'(bus.dist_cm), 64'(e_dist));
      chk("alarm_held", 64'(bus.near_alarm), 64'(e_alarm));
      chk("soc_after_to", 64'(bus.adc_soc), 64'd1);
      wait_for(W_SOC, 1'b0, 20, "soc_fall", n);
      chk("soc_width", 64'(n), 64'(SOCC));
    end
    if (eoc_dly > 0) begin
      repeat (eoc_dly) @(negedge clk);
      bus.adc_dout = dout;
      bus.adc_eoc  = 1'b1;
      q_temp.push_back(dout);
      wait_for(W_TVLD, 1'b1, 10, "temp_vld", n);
      chk("temp_latency", 64'(n), 64'd3);
      t = q_temp.pop_front();
      last_temp = t;
      chk("temp_raw", 64'(bus.temp_raw), 64'(t));
      chk("adc_err_clr", 64'(bus.adc_err), 64'd0);
      chk("busy_in_done", 64'(bus.busy), 64'd1);
      @(negedge clk);
      bus.adc_eoc  = 1'b0;
      bus.adc_dout = ~dout;
      chk("temp_vld_pulse", 64'(bus.temp_vld), 64'd0);
      chk("busy_fall", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("temp_held", 64'(bus.temp_raw), 64'(last_temp));
    end else begin
      wait_for(W_AERR, 1'b1, int'(ATO) + 20, "adc_err_set", n);
      chk("adc_to_cycles", 64'(n), 64'(ATO));
      chk("temp_kept", 64'(bus.temp_raw), 64'(last_temp));
      @(negedge clk);
      chk("busy_fall_to", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    n_chk        = 0;
    n_pass       = 0;
    last_temp    = 12'd0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.echo     = 1'b0;
    bus.adc_eoc  = 1'b0;
    bus.adc_dout = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // Good range (10 cm) and good conversion.
    run_seq(205, 16'd10, 1'b1, 30, 12'h3A5, 1'b0);
    // Echo timeout: distance and alarm held, ADC still converts.
    run_seq(0, 16'd10, 1'b1, 30, 12'h123, 1'b0);
    // Good range clears echo_err; ADC timeout.
    run_seq(70 * 20 + 11, 16'd70, 1'b0, 0, 12'h000, 1'b0);
    // Alarm band sequence; the last one also drops en mid-sequence.
    run_seq(59 * 20 + 11, 16'd59, 1'b1, 30, 12'h0F0, 1'b0);
    run_seq(62 * 20 + 11, 16'd62, ALARM_62, 30, 12'hABC, 1'b0);
    run_seq(66 * 20 + 11, 16'd66, 1'b0, 30, 12'h555, 1'b1);
    bus.en = 1'b1;

    // Reset pulse while trig is high.
    wait_for(W_TRIG, 1'b1, int'(PER) + 50, "trig_rise_rst", n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_trig_clear", 64'(bus.trig), 64'd0);
    chk("async_outs_clear", all_outs(), 64'd0);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_outs", all_outs(), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * int'(PER) + 100; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.trig !== 1'b0) seen = 1'b1;
    end
    chk("en0_blocks_ticks", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
